// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and the
// effective-divisor helper used by both the TX and RX baud counters.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_FETCH  = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
        TX_PARITY = 3'd4,
        TX_STOP   = 3'd5
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // A programmed divisor of zero behaves as one clock per bit.
    function automatic logic [15:0] baud_eff(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: latches a divisor on start_i and flags the last clock of
// every bit period; also tells the caller whether the next clock is one.
module uart_baud_counter
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] div_i,
    output logic        bit_end_o,
    output logic        bit_end_next_o
);

    logic [15:0] div_q;
    logic [15:0] div_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] div_eff;

    assign div_eff = baud_eff(div_i);

    // Next-state: load on start, reload after each period end, else count down.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (start_i) begin
            div_d = div_eff;
            cnt_d = div_eff - 16'd1;
        end else if (cnt_q == 16'd0) begin
            cnt_d = div_q - 16'd1;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // Divisor and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= 16'd1;
            cnt_q <= 16'd0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o      = (cnt_q == 16'd0);
    assign bit_end_next_o = (cnt_d == 16'd0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops words from the TX FIFO and serialises them as
// start / data (LSB first) / optional parity / stop bits at a runtime baud rate.
module uart_tx
    import uart_pkg::*;
#(
    parameter int WORD      = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tx_en_i,
    input  logic [15:0]     baud_div_i,
    input  logic            fifo_empty_i,
    input  logic [WORD-1:0] fifo_data_i,
    output logic            fifo_rd_o,
    output logic            tx_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam logic [2:0] LAST_IDX  = 3'(WORD - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    tx_state_t       state_q;
    logic [WORD-1:0] shift_q;
    logic [2:0]      bit_idx_q;
    logic            stop_idx_q;
    logic            par_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;
    logic            baud_start;
    logic            bit_end;
    logic            bit_end_next;

    function automatic logic parity_of(input logic [WORD-1:0] data);
        return (PARITY == PARITY_ODD) ? ~^data : ^data;
    endfunction

    // Reset is folded in so no pop can be issued while the block is held in reset.
    assign fifo_rd_o  = (state_q == TX_IDLE) & tx_en_i & ~fifo_empty_i & ~rst_i;
    assign baud_start = (state_q == TX_FETCH);

    uart_baud_counter u_baud (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (baud_start),
        .div_i          (baud_div_i),
        .bit_end_o      (bit_end),
        .bit_end_next_o (bit_end_next)
    );

    // Frame FSM with registered line, busy and done outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (fifo_rd_o) begin
                        state_q <= TX_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                TX_FETCH: begin
                    shift_q <= fifo_data_i;
                    par_q   <= parity_of(fifo_data_i);
                    tx_q    <= 1'b0;
                    state_q <= TX_START;
                end
                TX_START: begin
                    if (bit_end) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[WORD-1:1]};
                        bit_idx_q <= LAST_IDX;
                        state_q   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q != 3'd0) begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[WORD-1:1]};
                            bit_idx_q <= bit_idx_q - 3'd1;
                        end else if (PARITY != PARITY_NONE) begin
                            tx_q    <= par_q;
                            state_q <= TX_PARITY;
                        end else begin
                            tx_q       <= 1'b1;
                            stop_idx_q <= STOP_LAST;
                            done_q     <= (STOP_LAST == 1'b0) && bit_end_next;
                            state_q    <= TX_STOP;
                        end
                    end
                end
                TX_PARITY: begin
                    if (bit_end) begin
                        tx_q       <= 1'b1;
                        stop_idx_q <= STOP_LAST;
                        done_q     <= (STOP_LAST == 1'b0) && bit_end_next;
                        state_q    <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    // done_q is raised one clock early so it lines up with the final stop clock.
                    if (bit_end) begin
                        if (stop_idx_q == 1'b0) begin
                            state_q <= TX_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_idx_q <= 1'b0;
                            done_q     <= bit_end_next;
                        end
                    end else begin
                        done_q <= (stop_idx_q == 1'b0) && bit_end_next;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity, even, odd, even + 2 stop) fed
// by bench FIFOs and checked every cycle against a frame-arithmetic model.
module tb_uart_tx;

    localparam int NI = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          tx_en = 1'b0;
    logic [15:0]   baud  = 16'd4;
    logic [NI-1:0] tx_w;
    logic [NI-1:0] busy_w;
    logic [NI-1:0] done_w;
    logic [NI-1:0] rd_w;
    logic [NI-1:0] empty_w;
    logic [7:0]    rdata_q [NI] = '{default: 8'h00};
    logic [7:0]    mem [NI][16];
    int            head [NI] = '{default: 0};
    int            tail [NI] = '{default: 0};

    int            n_tests = 0;
    int            n_fail  = 0;

    // Written by the stimulus process only.
    int            scen = 0;
    int            exp_len [NI] = '{41, 45, 45, 49};
    logic [NI-1:0] exp_par = 4'b1010;
    int            exp_pops = 0;
    int            req_id = 0;
    int            timeouts = 0;

    // Written by the compare process only.
    logic          active [NI] = '{default: 1'b0};
    logic          pend   [NI] = '{default: 1'b0};
    logic [7:0]    m_word [NI] = '{default: 8'h00};
    int            m_d     [NI] = '{default: 1};
    int            m_start [NI] = '{default: 0};
    int            last_pop [NI] = '{default: -1000};
    int            pops     [NI] = '{default: 0};
    int            cyc = 0;
    int            seen_req = 0;
    logic          seen_to = 1'b0;
    logic [7:0]    cap = 8'h00;
    logic          e_tx, e_busy, e_done, e_rd;
    int            off, bitno, nb, off2;

    always #5 clk = ~clk;

    function automatic int par_of(input int g);
        return (g == 2) ? 2 : ((g == 0) ? 0 : 1);
    endfunction

    function automatic int stop_of(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    // Line level for bit slot n of a frame carrying w.
    function automatic logic frame_bit(input logic [7:0] w, input int par, input int n);
        int ones;
        ones = $countones(w);
        if (n == 0) return 1'b0;
        if (n <= 8) return w[n-1];
        if (par != 0 && n == 9) return (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
        return 1'b1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign empty_w[g] = (head[g] == tail[g]);
        uart_tx #(
            .WORD      (8),
            .PARITY    ((g == 2) ? 2 : ((g == 0) ? 0 : 1)),
            .STOP_BITS ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .tx_en_i      (tx_en),
            .baud_div_i   (baud),
            .fifo_empty_i (empty_w[g]),
            .fifo_data_i  (rdata_q[g]),
            .fifo_rd_o    (rd_w[g]),
            .tx_o         (tx_w[g]),
            .busy_o       (busy_w[g]),
            .done_o       (done_w[g])
        );
    end

    // Bench FIFOs with registered read data.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (rd_w[g] && head[g] != tail[g]) begin
                rdata_q[g] <= mem[g][head[g]];
                head[g]    <= head[g] + 1;
            end
        end
    end

    task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", nm, g, cyc, act, exp);
        end
    endtask

    // Model + compare, once per cycle away from the active edge.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0;
            if (rst) begin
                active[g] = 1'b0;
                pend[g]   = 1'b0;
            end else if (pend[g]) begin
                e_busy     = 1'b1;
                pend[g]    = 1'b0;
                active[g]  = 1'b1;
                m_start[g] = cyc + 1;
                m_d[g]     = (baud == 16'd0) ? 1 : int'(baud);
            end else if (active[g]) begin
                off    = cyc - m_start[g];
                bitno  = off / m_d[g];
                nb     = 9 + ((par_of(g) != 0) ? 1 : 0) + stop_of(g);
                e_busy = 1'b1;
                e_tx   = frame_bit(m_word[g], par_of(g), bitno);
                e_done = (off == nb * m_d[g] - 1);
                if (e_done) active[g] = 1'b0;
            end else begin
                e_rd = tx_en && !empty_w[g];
                if (e_rd) begin
                    pend[g]   = 1'b1;
                    m_word[g] = mem[g][head[g]];
                end
            end
            check("tx_o", g, 32'(tx_w[g]), 32'(e_tx));
            check("busy_o", g, 32'(busy_w[g]), 32'(e_busy));
            check("done_o", g, 32'(done_w[g]), 32'(e_done));
            check("fifo_rd_o", g, 32'(rd_w[g]), 32'(e_rd));

            if (rd_w[g]) begin
                last_pop[g] = cyc;
                pops[g]     = pops[g] + 1;
            end
            if (done_w[g] && exp_len[g] != 0)
                check("pop_to_done", g, 32'(cyc - last_pop[g]), 32'(exp_len[g]));
            if (g != 0 && scen == 1 && cyc - last_pop[g] == 39)
                check("parity_bit", g, 32'(tx_w[g]), 32'(exp_par[g]));
        end

        if (scen == 1) begin
            off2 = cyc - last_pop[0] - 3;
            if (off2 >= 4 && off2 <= 32 && off2 % 4 == 0) begin
                cap[off2 / 4 - 1] = tx_w[0];
                if (off2 == 32) check("a5_bits", 0, 32'(cap), 32'h0000_00A5);
            end
        end
        if (req_id != seen_req) begin
            seen_req = req_id;
            check("pop_count", 0, 32'(pops[0]), 32'(exp_pops));
        end
        if (timeouts != 0 && !seen_to) begin
            seen_to = 1'b1;
            n_tests++;
            n_fail++;
            $display("FAIL wait_pop timeout cyc=%0d got=no pop expected=pop", cyc);
        end
        cyc++;
    end

    task automatic push(input int g, input logic [7:0] w);
        mem[g][tail[g]] = w;
        tail[g]         = tail[g] + 1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pop();
        int i;
        i = 0;
        while (!rd_w[0] && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (!rd_w[0]) timeouts++;
    endtask

    task automatic ask_pops(input int n);
        exp_pops = n;
        req_id++;
        wait_cycles(1);
    endtask

    initial begin
        wait_cycles(3);
        rst = 1'b0;

        // 0xA5 on the plain instance, 0x07 on the three parity variants.
        scen = 1;
        push(0, 8'hA5); push(1, 8'h07); push(2, 8'h07); push(3, 8'h07);
        tx_en = 1'b1;
        wait_cycles(60);
        ask_pops(1);

        // Back-to-back words.
        scen = 2;
        push(0, 8'h55); push(0, 8'h0F);
        wait_cycles(100);
        ask_pops(3);

        // Disabled with data queued: nothing may leave.
        tx_en = 1'b0;
        push(0, 8'h81); push(0, 8'hE7); push(0, 8'h3C);
        wait_cycles(20);
        ask_pops(3);

        // Enable drops during DATA: frame completes, no further pop.
        tx_en = 1'b1;
        #1;
        wait_pop();
        wait_cycles(10);
        tx_en = 1'b0;
        wait_cycles(50);
        ask_pops(4);

        // Reset during data bit 3 of 0xE7, then 0x3C goes out whole.
        tx_en = 1'b1;
        #1;
        wait_pop();
        wait_cycles(19);
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(50);
        ask_pops(6);

        // Divisor 0 acts as 1 clock per bit.
        baud       = 16'd0;
        exp_len[0] = 11;
        push(0, 8'hC3);
        wait_cycles(20);
        ask_pops(7);

        // Divisor change mid-frame keeps the latched value.
        baud       = 16'd4;
        exp_len[0] = 41;
        push(0, 8'h5A);
        #1;
        wait_pop();
        wait_cycles(8);
        baud = 16'd7;
        wait_cycles(60);
        ask_pops(8);

        wait_cycles(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
